// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 800x600 VGA timing constants and pixel-pipeline types.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_H_ACTIVE = 800;
    localparam int c_H_FP     = 40;
    localparam int c_H_SYNC   = 128;
    localparam int c_H_BP     = 88;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_ACTIVE = 600;
    localparam int c_V_FP     = 1;
    localparam int c_V_SYNC   = 4;
    localparam int c_V_BP     = 23;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic first;
    } pix_ctrl_t;

    // True when cnt lies in [lo, lo+len-1].
    function automatic logic sync_in_window(input logic [10:0] cnt, input int lo, input int len);
        return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fb_addr.sv
// ============================================================================
// Module   : vga_fb_addr
// Brief    : Combinational framebuffer address, y*FB_W + x.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_addr #(
    parameter int FB_W   = 200,
    parameter int ADDR_W = 15
) (
    input  logic [8:0]        i_x,
    input  logic [8:0]        i_y,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_x;
    logic [ADDR_W-1:0] w_y;

    assign w_x = ADDR_W'(i_x);
    assign w_y = ADDR_W'(i_y);

    generate
        if (FB_W == 200) begin : g_shift_add
            // 200 = 128 + 64 + 8
            assign o_addr = (w_y << 7) + (w_y << 6) + (w_y << 3) + w_x;
        end else begin : g_mult
            assign o_addr = w_y * ADDR_W'(FB_W) + w_x;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_pixel_pipe.sv
// ============================================================================
// Module   : vga_pixel_pipe
// Brief    : H/V count decode, framebuffer fetch and aligned sync/RGB output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_pipe
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter bit SYNC_POL = 1'b1,
    parameter int FB_W     = 200,
    parameter int ADDR_W   = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PIX_EN,
    input  logic [10:0]       Hcnt,
    input  logic [10:0]       Vcnt,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [11:0]       fb_rdata,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              active,
    output logic              frame_start,
    output logic [7:0]        frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic              w_in_range;
    pix_ctrl_t         w_dec;
    logic [ADDR_W-1:0] w_addr;
    rgb12_t            w_s1_pix;

    pix_ctrl_t         r_s0;
    pix_ctrl_t         r_s1;
    logic              r_en_d;
    rgb12_t            r_pix1;

    always_comb begin
        w_in_range = (int'(Hcnt) < H_TOTAL) && (int'(Vcnt) < V_TOTAL);
        w_dec       = '0;
        w_dec.vis   = w_in_range && (int'(Hcnt) < H_ACTIVE) && (int'(Vcnt) < V_ACTIVE);
        w_dec.hs    = w_in_range && sync_in_window(Hcnt, H_ACTIVE + H_FP, H_SYNC);
        w_dec.vs    = w_in_range && sync_in_window(Vcnt, V_ACTIVE + V_FP, V_SYNC);
        w_dec.first = (Hcnt == 11'd0) && (Vcnt == 11'd0);
    end

    vga_fb_addr #(
        .FB_W   (FB_W),
        .ADDR_W (ADDR_W)
    ) u_fb_addr (
        .i_x    (Hcnt[10:2]),
        .i_y    (Vcnt[10:2]),
        .o_addr (w_addr)
    );

    // RAM data is live only on the clock right after a beat; during a stall it
    // is caught in r_pix1 before the next read (issued by fb_rd) overwrites it.
    assign w_s1_pix = r_en_d ? rgb12_t'(fb_rdata) : r_pix1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s0        <= '0;
            r_s1        <= '0;
            r_en_d      <= 1'b0;
            r_pix1      <= '0;
            fb_rd       <= 1'b0;
            fb_addr     <= '0;
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
            VGA_R       <= 4'd0;
            VGA_G       <= 4'd0;
            VGA_B       <= 4'd0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            r_en_d      <= PIX_EN;
            r_pix1      <= w_s1_pix;
            fb_rd       <= 1'b0;
            frame_start <= 1'b0;
            if (PIX_EN) begin
                r_s0  <= w_dec;
                r_s1  <= r_s0;
                fb_rd <= w_dec.vis;
                if (w_dec.vis) begin
                    fb_addr <= w_addr;
                end
                VGA_R       <= r_s1.vis ? w_s1_pix.r : 4'd0;
                VGA_G       <= r_s1.vis ? w_s1_pix.g : 4'd0;
                VGA_B       <= r_s1.vis ? w_s1_pix.b : 4'd0;
                HSYNC       <= r_s1.hs ^ ~SYNC_POL;
                VSYNC       <= r_s1.vs ^ ~SYNC_POL;
                active      <= r_s1.vis;
                frame_start <= r_s1.first;
                if (r_s1.first) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_pipe.sv
// ============================================================================
// Module   : tb_vga_pixel_pipe
// Brief    : Directed self-checking bench for vga_pixel_pipe with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_pipe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PIX_EN = 1'b0;
    logic [10:0] Hcnt = 11'd0;
    logic [10:0] Vcnt = 11'd0;
    logic        fb_rd;
    logic [14:0] fb_addr;
    logic [11:0] fb_rdata = 12'd0;
    logic        HSYNC;
    logic        VSYNC;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        active;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [11:0] w_rgb;

    int          n_total = 0;
    int          n_bad   = 0;
    logic        ram_const_en = 1'b0;
    logic [11:0] ram_const = 12'd0;
    int          hs_h [4] = '{839, 840, 967, 968};
    int          vs_v [4] = '{600, 601, 604, 605};
    logic        sync_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    vga_pixel_pipe u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .PIX_EN      (PIX_EN),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .fb_rd       (fb_rd),
        .fb_addr     (fb_addr),
        .fb_rdata    (fb_rdata),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .active      (active),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    assign w_rgb = {VGA_R, VGA_G, VGA_B};

    always #5 CLK = ~CLK;

    function automatic logic [11:0] ram_word(input logic [14:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    // 1-cycle synchronous RAM; the forced mode drives a constant word every clock.
    always @(posedge CLK) begin
        if (ram_const_en) fb_rdata <= ram_const;
        else if (fb_rd)   fb_rdata <= ram_word(fb_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input int h, input int v, input logic en);
        Hcnt   = 11'(h);
        Vcnt   = 11'(v);
        PIX_EN = en;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // power-on reset
        repeat (3) beat(0, 0, 1'b1);
        chk("rst_hsync", HSYNC, 0);
        chk("rst_vsync", VSYNC, 0);
        chk("rst_rgb", w_rgb, 0);
        chk("rst_active", active, 0);
        chk("rst_fb_rd", fb_rd, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fstart", frame_start, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // sync pulses in flight, then reset mid-frame
        RST = 1'b0;
        repeat (3) beat(900, 602, 1'b1);
        chk("pre_hsync", HSYNC, 1);
        chk("pre_vsync", VSYNC, 1);
        RST = 1'b1;
        repeat (3) beat(100, 50, 1'b1);
        chk("mid_rst_hsync", HSYNC, 0);
        chk("mid_rst_vsync", VSYNC, 0);
        chk("mid_rst_rgb", w_rgb, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_fcnt", frame_cnt, 0);
        RST = 1'b0;
        beat(100, 50, 1'b1);
        chk("post_rst_b1_active", active, 0);
        chk("post_rst_b1_addr", fb_addr, 2425);
        beat(104, 50, 1'b1);
        chk("post_rst_b2_active", active, 0);
        beat(108, 50, 1'b1);
        chk("post_rst_b3_active", active, 1);
        chk("post_rst_b3_rgb", w_rgb, 12'hCDC);

        // latency and address
        ram_const_en = 1'b1;
        ram_const    = 12'hABC;
        beat(4, 8, 1'b1);
        chk("addr_401", fb_addr, 401);
        chk("addr_rd", fb_rd, 1);
        beat(800, 8, 1'b1);
        chk("addr_hold", fb_addr, 401);
        chk("addr_rd_blank", fb_rd, 0);
        beat(800, 8, 1'b1);
        chk("lat_r", VGA_R, 4'hA);
        chk("lat_g", VGA_G, 4'hB);
        chk("lat_b", VGA_B, 4'hC);
        chk("lat_active", active, 1);

        // blanking with RAM forced to white
        ram_const = 12'hFFF;
        repeat (3) beat(800, 8, 1'b1);
        chk("blank_rgb", w_rgb, 0);
        chk("blank_active", active, 0);
        chk("blank_fb_rd", fb_rd, 0);
        ram_const_en = 1'b0;

        // sync window edges, 3 beats of latency
        for (int i = 0; i < 6; i++) begin
            beat((i < 4) ? hs_h[i] : 800, 8, 1'b1);
            if (i >= 2) chk($sformatf("hsync_%0d", hs_h[i-2]), HSYNC, sync_exp[i-2]);
        end
        for (int i = 0; i < 6; i++) begin
            beat(10, (i < 4) ? vs_v[i] : 610, 1'b1);
            if (i >= 2) chk($sformatf("vsync_%0d", vs_v[i-2]), VSYNC, sync_exp[i-2]);
        end

        // out-of-range counts decode as blank, sync inactive
        repeat (3) beat(900, 700, 1'b1);
        chk("oor_v_hsync", HSYNC, 0);
        chk("oor_v_active", active, 0);
        repeat (3) beat(1100, 602, 1'b1);
        chk("oor_h_vsync", VSYNC, 0);
        chk("oor_h_hsync", HSYNC, 0);

        // frame wrap
        beat(1055, 627, 1'b1);
        beat(0, 0, 1'b1);
        beat(1, 0, 1'b1);
        chk("wrap_fs_early", frame_start, 0);
        beat(4, 0, 1'b1);
        chk("wrap_fs", frame_start, 1);
        chk("wrap_fcnt1", frame_cnt, 1);
        chk("wrap_rgb00", w_rgb, 12'h5A5);
        beat(8, 0, 1'b1);
        chk("wrap_fs_single", frame_start, 0);
        chk("wrap_fcnt_hold", frame_cnt, 1);
        for (int k = 0; k < 254; k++) begin
            beat(0, 0, 1'b1);
            beat(1055, 627, 1'b1);
        end
        repeat (2) beat(1055, 627, 1'b1);
        chk("fcnt_255", frame_cnt, 255);
        beat(0, 0, 1'b1);
        beat(1055, 627, 1'b1);
        beat(1055, 627, 1'b1);
        chk("fcnt_wrap_fs", frame_start, 1);
        chk("fcnt_wrap_0", frame_cnt, 0);

        // stall mid-line
        beat(8, 4, 1'b1);
        beat(12, 4, 1'b1);
        beat(16, 4, 1'b1);
        beat(20, 4, 1'b1);
        chk("stall_pre_rgb", w_rgb, ram_word(15'd203));
        for (int s = 0; s < 5; s++) begin
            beat(0, 0, 1'b0);
            chk($sformatf("stall%0d_rgb", s), w_rgb, ram_word(15'd203));
            chk($sformatf("stall%0d_active", s), active, 1);
            chk($sformatf("stall%0d_fb_rd", s), fb_rd, 0);
            chk($sformatf("stall%0d_addr", s), fb_addr, 205);
            chk($sformatf("stall%0d_fs", s), frame_start, 0);
            chk($sformatf("stall%0d_fcnt", s), frame_cnt, 0);
        end
        beat(24, 4, 1'b1);
        chk("resume_204", w_rgb, ram_word(15'd204));
        beat(28, 4, 1'b1);
        chk("resume_205", w_rgb, ram_word(15'd205));
        beat(800, 4, 1'b1);
        chk("resume_206", w_rgb, ram_word(15'd206));
        beat(800, 4, 1'b1);
        chk("resume_207", w_rgb, ram_word(15'd207));
        beat(800, 4, 1'b1);
        chk("resume_blank", active, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
